// File: rtl/port_clkstat_pkg.sv
// -----------------------------------------------------------------------------
// port_clkstat_pkg
//   Shared definitions for the clock-status readback port.
//   - state_e        : response FSM states (IDLE, SEND)
//   - START/FREERUN/RUNNING : bit positions inside the control/status byte,
//                      common with the clock-control port's control mask
//   - frame_len()    : response frame length for a given count width
// -----------------------------------------------------------------------------
package port_clkstat_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Bit positions inside the control/status byte.
    localparam int START   = 0;
    localparam int FREERUN = 1;
    localparam int RUNNING = 2;

    // Response layout: sequence byte, status byte, then the count bytes.
    function automatic int frame_len(input int count_bytes);
        return count_bytes + 2;
    endfunction

endpackage : port_clkstat_pkg

// File: rtl/port_clkstat.sv
// -----------------------------------------------------------------------------
// port_clkstat
//   Transmit side of the PATLPP clock-control port. Each accepted request frame
//   (content ignored, end marked by in_eof) snapshots the gated-cycle count and
//   the control/status byte, then returns them as a fixed-length response:
//     byte 0            : sequence number (increments per completed frame)
//     byte 1            : status snapshot
//     byte 2..FRAME_LEN-1 : count snapshot, most significant byte first
//
// Ports
//   clk, rst            system clock; asynchronous active-low reset
//   en                  gates request acceptance only
//   in_data/in_sof      request data and start marker (ignored)
//   in_eof, in_src_rdy  request end marker and valid
//   in_dst_rdy          high while idle (ready for a request)
//   cnt_in, stat_in     live count and status, already synchronous to clk
//   out_data/sof/eof    registered response byte and frame markers
//   out_src_rdy         response byte valid
//   out_dst_rdy         downstream accepts the response byte
// -----------------------------------------------------------------------------
module port_clkstat
    import port_clkstat_pkg::*;
#(
    parameter int COUNT_BYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [7:0]               in_data,
    input  logic                     in_sof,
    input  logic                     in_eof,
    input  logic                     in_src_rdy,
    input  logic                     out_dst_rdy,
    input  logic [8*COUNT_BYTES-1:0] cnt_in,
    input  logic [7:0]               stat_in,
    output logic [7:0]               out_data,
    output logic                     out_sof,
    output logic                     out_eof,
    output logic                     out_src_rdy,
    output logic                     in_dst_rdy
);

    localparam int                 FRAME_LEN = frame_len(COUNT_BYTES);
    localparam int                 IDX_W     = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(FRAME_LEN - 1);

    state_e                   state_q;
    logic [7:0]               seq_q;
    logic [8*COUNT_BYTES-1:0] cnt_snap_q;
    logic [7:0]               stat_snap_q;
    logic [IDX_W-1:0]         idx_q;
    logic [7:0]               out_data_q;
    logic                     out_sof_q;
    logic                     out_eof_q;
    logic                     out_src_rdy_q;

    logic [IDX_W-1:0]         idx_d;
    logic [7:0]               byte_d;

    // Request content and start marker carry no information for this port.
    logic unused_inputs;
    assign unused_inputs = ^{in_data, in_sof};

    assign in_dst_rdy  = (state_q == IDLE);
    assign out_data    = out_data_q;
    assign out_sof     = out_sof_q;
    assign out_eof     = out_eof_q;
    assign out_src_rdy = out_src_rdy_q;

    // Byte that follows the one currently presented. Byte 0 (sequence) is
    // loaded directly on request acceptance, so only idx 1.. is selected here.
    always_comb begin
        // NOTE: default first so every path assigns byte_d; no latch is inferred.
        idx_d  = idx_q + 1'b1;
        byte_d = 8'h00;
        if (idx_d == IDX_W'(1)) begin
            byte_d = stat_snap_q;
        end
        for (int b = 0; b < COUNT_BYTES; b++) begin
            if (idx_d == IDX_W'(b + 2)) begin
                byte_d = cnt_snap_q[8*(COUNT_BYTES-1-b) +: 8];
            end
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the snapshot registers are few and architecturally visible
            // after reset, so they are reset along with the control state.
            state_q       <= IDLE;
            seq_q         <= 8'h00;
            cnt_snap_q    <= '0;
            stat_snap_q   <= 8'h00;
            idx_q         <= '0;
            out_data_q    <= 8'h00;
            out_sof_q     <= 1'b0;
            out_eof_q     <= 1'b0;
            out_src_rdy_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // in_dst_rdy is implied by being in IDLE.
                    if (en && in_src_rdy && in_eof) begin
                        state_q       <= SEND;
                        cnt_snap_q    <= cnt_in;
                        stat_snap_q   <= stat_in;
                        idx_q         <= '0;
                        out_data_q    <= seq_q;
                        out_sof_q     <= 1'b1;
                        out_eof_q     <= 1'b0;
                        out_src_rdy_q <= 1'b1;
                    end
                end
                SEND: begin
                    if (out_dst_rdy) begin
                        if (idx_q == LAST_IDX) begin
                            state_q       <= IDLE;
                            seq_q         <= seq_q + 8'h01;
                            idx_q         <= '0;
                            out_data_q    <= 8'h00;
                            out_sof_q     <= 1'b0;
                            out_eof_q     <= 1'b0;
                            out_src_rdy_q <= 1'b0;
                        end else begin
                            idx_q      <= idx_d;
                            out_data_q <= byte_d;
                            out_sof_q  <= 1'b0;
                            out_eof_q  <= (idx_d == LAST_IDX);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule : port_clkstat

// File: tb/tb_port_clkstat.sv
// -----------------------------------------------------------------------------
// tb_port_clkstat
//   Directed bench for port_clkstat (COUNT_BYTES = 4, six-byte frames).
//   Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_port_clkstat;
    import port_clkstat_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_sof = 1'b0;
    logic        in_eof = 1'b0;
    logic        in_src_rdy = 1'b0;
    logic        out_dst_rdy = 1'b0;
    logic [31:0] cnt_in = 32'h0;
    logic [7:0]  stat_in = 8'h00;
    logic [7:0]  out_data;
    logic        out_sof;
    logic        out_eof;
    logic        out_src_rdy;
    logic        in_dst_rdy;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_seq  = 8'h00;

    port_clkstat #(.COUNT_BYTES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .in_data     (in_data),
        .in_sof      (in_sof),
        .in_eof      (in_eof),
        .in_src_rdy  (in_src_rdy),
        .out_dst_rdy (out_dst_rdy),
        .cnt_in      (cnt_in),
        .stat_in     (stat_in),
        .out_data    (out_data),
        .out_sof     (out_sof),
        .out_eof     (out_eof),
        .out_src_rdy (out_src_rdy),
        .in_dst_rdy  (in_dst_rdy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Presents an n-byte request, one byte per cycle; returns on the falling
    // edge after the eof byte's rising edge.
    task automatic send_req(input int n);
        for (int i = 0; i < n; i++) begin
            in_src_rdy = 1'b1;
            in_sof     = (i == 0);
            in_eof     = (i == n - 1);
            in_data    = 8'hA0 + 8'(i);
            @(negedge clk);
        end
        in_src_rdy = 1'b0;
        in_sof     = 1'b0;
        in_eof     = 1'b0;
    endtask

    // Receives one frame starting on the cycle after request eof. stall=1 uses
    // the ready pattern 1,0,0,1 repeating; bump=1 increments cnt_in each cycle.
    // Byte/sof/eof are checked every cycle, so stalled cycles verify holding.
    task automatic recv_frame(input string tag, input logic [47:0] exp,
                              input bit stall, input bit bump);
        int got_n = 0;
        int cyc   = 0;
        while (got_n < 6 && cyc < 60) begin
            out_dst_rdy = stall ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            check({tag, "_valid"},  32'(out_src_rdy), 32'd1);
            check({tag, "_in_rdy"}, 32'(in_dst_rdy),  32'd0);
            check({tag, "_data"},   32'(out_data),    32'(exp[47 - 8*got_n -: 8]));
            check({tag, "_sof"},    32'(out_sof),     32'(got_n == 0));
            check({tag, "_eof"},    32'(out_eof),     32'(got_n == 5));
            if (out_src_rdy && out_dst_rdy) got_n++;
            if (bump) cnt_in = cnt_in + 32'd1;
            @(negedge clk);
            cyc++;
        end
        out_dst_rdy = 1'b0;
        check({tag, "_count"},     32'(got_n),       32'd6);
        check({tag, "_end_valid"}, 32'(out_src_rdy), 32'd0);
        check({tag, "_end_rdy"},   32'(in_dst_rdy),  32'd1);
        exp_seq = exp_seq + 8'h01;
    endtask

    initial begin
        logic [31:0] cnt_at_req;

        // Reset state.
        #3;
        check("rst_valid", 32'(out_src_rdy), 32'd0);
        check("rst_data",  32'(out_data),    32'd0);
        check("rst_sof",   32'(out_sof),     32'd0);
        check("rst_eof",   32'(out_eof),     32'd0);
        check("rst_in_rdy", 32'(in_dst_rdy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;
        @(negedge clk);

        // Basic frame: 3-byte request, continuous ready.
        cnt_in  = 32'h12345678;
        stat_in = 8'h03;
        send_req(3);
        recv_frame("basic", {8'h00, 8'h03, 32'h12345678}, 1'b0, 1'b0);

        // Backpressure with ready pattern 1,0,0,1.
        cnt_in  = 32'hDEADBEEF;
        stat_in = 8'h1 << RUNNING;
        send_req(1);
        recv_frame("bp", {exp_seq, 8'h04, 32'hDEADBEEF}, 1'b1, 1'b0);

        // Snapshot integrity: count moves every cycle during the frame.
        cnt_in  = 32'h000000FE;
        stat_in = 8'h05;
        send_req(2);
        cnt_at_req = 32'h000000FE;
        recv_frame("snap", {exp_seq, 8'h05, cnt_at_req}, 1'b1, 1'b1);

        // Enable gating in IDLE: eof pulses are ignored, ready still reads 1.
        en         = 1'b0;
        in_src_rdy = 1'b1;
        in_eof     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("en0_valid",  32'(out_src_rdy), 32'd0);
            check("en0_in_rdy", 32'(in_dst_rdy),  32'd1);
        end
        in_src_rdy = 1'b0;
        in_eof     = 1'b0;
        en         = 1'b1;

        // Enable dropped mid-frame: frame still completes.
        cnt_in  = 32'hCAFE0001;
        stat_in = 8'h02;
        send_req(1);
        en = 1'b0;
        recv_frame("en_mid", {exp_seq, 8'h02, 32'hCAFE0001}, 1'b0, 1'b0);
        en = 1'b1;

        // Second request held off during SEND, then served after eof.
        cnt_in  = 32'h01020304;
        stat_in = 8'h01;
        send_req(1);
        in_src_rdy = 1'b1;
        in_eof     = 1'b1;
        recv_frame("hold1", {exp_seq, 8'h01, 32'h01020304}, 1'b0, 1'b0);
        @(negedge clk);
        in_src_rdy = 1'b0;
        in_eof     = 1'b0;
        recv_frame("hold2", {exp_seq, 8'h01, 32'h01020304}, 1'b0, 1'b0);

        // Asynchronous reset at byte idx3.
        cnt_in  = 32'h12345678;
        stat_in = 8'h03;
        send_req(1);
        out_dst_rdy = 1'b1;
        repeat (3) @(negedge clk);
        out_dst_rdy = 1'b0;
        check("arst_pre_data", 32'(out_data), 32'h34);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid",  32'(out_src_rdy), 32'd0);
        check("arst_data",   32'(out_data),    32'd0);
        check("arst_sof",    32'(out_sof),     32'd0);
        check("arst_eof",    32'(out_eof),     32'd0);
        check("arst_in_rdy", 32'(in_dst_rdy),  32'd1);
        @(negedge clk);
        rst = 1'b1;
        exp_seq = 8'h00;
        @(negedge clk);
        send_req(1);
        recv_frame("post_rst", {8'h00, 8'h03, 32'h12345678}, 1'b0, 1'b0);

        // Sequence wrap: the counter runs 01..FF, then 00.
        for (int i = 0; i < 256; i++) begin
            cnt_in  = 32'(i) * 32'h01010101;
            stat_in = 8'(i);
            send_req(1);
            recv_frame("wrap", {exp_seq, 8'(i), 32'(i) * 32'h01010101}, 1'b0, 1'b0);
        end
        check("wrap_seq_model", 32'(exp_seq), 32'h01);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_port_clkstat
